mems_report_scheduler: RTL

//  Shares the single 16-bit UART word sender between three report sources:
//  - SPI MEMS readback frame (low word, then high word)
//  - signal_angle pulse count
//  - signal_mid pulse count

---
 rtl/mems_report_scheduler_pkg.sv | 45 ++++
 rtl/mems_report_scheduler_if.sv | 32 +++
 rtl/mems_report_scheduler_pulse_event_counter.sv | 53 +++++
 rtl/mems_report_scheduler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mems_report_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mems_sched_pkg
//  Source IDs, FSM encoding and round-robin helpers for the report scheduler.
//  Rev    : 1.0
// ============================================================================
package mems_sched_pkg;

  typedef enum logic [1:0] {
    SRC_SPI   = 2'd0,
    SRC_ANGLE = 2'd1,
    SRC_MID   = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam logic [15:0] HDR_TAG = 16'hA500;

  // First requesting source at or after ptr (req bit index = source ID).
  function automatic src_e rr_pick(input src_e ptr, input logic [2:0] req);
    src_e pick;
    int   idx;
    pick = ptr;
    for (int k = 2; k >= 0; k--) begin
      idx = (int'(ptr) + k) % 3;
      if (req[idx]) pick = src_e'(idx[1:0]);
    end
    return pick;
  endfunction

  function automatic src_e rr_next(input src_e src);
    case (src)
      SRC_SPI:   return SRC_ANGLE;
      SRC_ANGLE: return SRC_MID;
      default:   return SRC_SPI;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mems_report_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module : mems_report_scheduler_if
//  Report sources in, UART word sender and status out.
//  Rev    : 1.0
// ============================================================================
interface mems_report_scheduler_if;
  logic        enable;
  logic        receive_done;
  logic [15:0] receive_data_L;
  logic [15:0] receive_data_H;
  logic        signal_angle;
  logic        signal_mid;
  logic [15:0] uart_data;
  logic        uart_start;
  logic        busy;
  logic [1:0]  grant_src;
  logic        spi_overrun;

  modport slave (
    input  enable, receive_done, receive_data_L, receive_data_H,
           signal_angle, signal_mid,
    output uart_data, uart_start, busy, grant_src, spi_overrun
  );

  modport master (
    output enable, receive_done, receive_data_L, receive_data_H,
           signal_angle, signal_mid,
    input  uart_data, uart_start, busy, grant_src, spi_overrun
  );
endinterface
`default_nettype wire

// File: rtl/mems_report_scheduler_pulse_event_counter.sv
`default_nettype none
// ============================================================================
//  Module : pulse_event_counter
//  Synchronises an async pulse, counts rising edges (saturating), snapshot-and-clear.
//  Rev    : 1.0
// ============================================================================
module pulse_event_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             sclk,
  input  wire logic             rst_n,
  input  wire logic             pulse_in,
  input  wire logic             clear,
  output logic [CNT_W-1:0]      count,
  output logic                  request
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic             w_rise;
  logic [CNT_W-1:0] r_count;

  assign w_rise = r_sync2 & ~r_sync3;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= pulse_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // An edge coinciding with the snapshot starts the next count at 1.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= w_rise ? CNT_W'(1) : '0;
    end else if (w_rise && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count   = r_count;
  assign request = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/mems_report_scheduler.sv
`default_nettype none
// ============================================================================
//  Module : mems_report_scheduler
//  Round-robin framing of SPI readback and pulse counts onto one UART sender.
//  Option : MEMS_SCHED_HEADER_EN prefixes each frame with HDR_TAG | grant_src.
//  Rev    : 1.0
// ============================================================================
module mems_report_scheduler
  import mems_sched_pkg::*;
#(
  parameter int unsigned START_HOLD = 6000,
  parameter int unsigned GAP_CYCLES = 500000,
  parameter int          CNT_W      = 16
) (
  input  wire logic               sclk,
  input  wire logic               rst_n,
  mems_report_scheduler_if.slave  bus
);

  logic             r_rd_d1;
  logic             r_rd_d2;
  logic             w_spi_edge;
  logic             r_spi_pend;
  logic [15:0]      r_spi_l;
  logic [15:0]      r_spi_h;
  logic             r_overrun;

  logic [CNT_W-1:0] w_angle_cnt;
  logic [CNT_W-1:0] w_mid_cnt;
  logic             w_angle_req;
  logic             w_mid_req;
  logic             w_clr_angle;
  logic             w_clr_mid;

  logic [2:0]       w_req;
  logic             w_grant;
  src_e             w_pick;
  src_e             r_rr_ptr;
  logic [1:0]       r_grant_src;

  state_e           r_state;
  state_e           w_state_next;
  logic [31:0]      r_timer;
  logic [1:0]       r_word_idx;
  logic [1:0]       r_nwords;
  logic             w_last_word;
  logic [2:0][15:0] r_words;
  logic [2:0][15:0] w_frame_words;
  logic [1:0]       w_frame_nwords;
  logic [15:0]      w_payload_lo;
  logic [15:0]      w_payload_hi;
  logic [15:0]      r_uart_data;

  pulse_event_counter #(.CNT_W(CNT_W)) u_angle (
    .sclk(sclk), .rst_n(rst_n), .pulse_in(bus.signal_angle),
    .clear(w_clr_angle), .count(w_angle_cnt), .request(w_angle_req)
  );

  pulse_event_counter #(.CNT_W(CNT_W)) u_mid (
    .sclk(sclk), .rst_n(rst_n), .pulse_in(bus.signal_mid),
    .clear(w_clr_mid), .count(w_mid_cnt), .request(w_mid_req)
  );

  assign w_spi_edge  = ~r_rd_d1 & r_rd_d2;
  assign w_req       = {w_mid_req, w_angle_req, r_spi_pend};
  assign w_grant     = (r_state == IDLE) && bus.enable && (w_req != 3'b000);
  assign w_pick      = rr_pick(r_rr_ptr, w_req);
  assign w_clr_angle = w_grant && (w_pick == SRC_ANGLE);
  assign w_clr_mid   = w_grant && (w_pick == SRC_MID);
  assign w_last_word = (r_word_idx == (r_nwords - 2'd1));

  // The grant snapshots the old buffer, so a same-cycle edge is not an overrun.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_d1    <= 1'b0;
      r_rd_d2    <= 1'b0;
      r_spi_pend <= 1'b0;
      r_spi_l    <= '0;
      r_spi_h    <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_rd_d1 <= bus.receive_done;
      r_rd_d2 <= r_rd_d1;
      if (w_spi_edge) begin
        r_spi_l    <= bus.receive_data_L;
        r_spi_h    <= bus.receive_data_H;
        r_spi_pend <= 1'b1;
      end else if (w_grant && (w_pick == SRC_SPI)) begin
        r_spi_pend <= 1'b0;
      end
      if (w_spi_edge && r_spi_pend && !(w_grant && (w_pick == SRC_SPI)))
        r_overrun <= 1'b1;
    end
  end

  always_comb begin
    w_payload_lo = r_spi_l;
    w_payload_hi = r_spi_h;
    case (w_pick)
      SRC_ANGLE: w_payload_lo = 16'(w_angle_cnt);
      SRC_MID:   w_payload_lo = 16'(w_mid_cnt);
      default:   ;
    endcase
`ifdef MEMS_SCHED_HEADER_EN
    w_frame_words  = {w_payload_hi, w_payload_lo, HDR_TAG | {14'd0, w_pick}};
    w_frame_nwords = (w_pick == SRC_SPI) ? 2'd3 : 2'd2;
`else
    w_frame_words  = {16'd0, w_payload_hi, w_payload_lo};
    w_frame_nwords = (w_pick == SRC_SPI) ? 2'd2 : 2'd1;
`endif
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_grant) w_state_next = LOAD;
      LOAD: w_state_next = HOLD;
      HOLD: if (r_timer == 32'(START_HOLD - 1)) w_state_next = GAP;
      GAP:  if (r_timer == 32'(GAP_CYCLES - 1))
              w_state_next = w_last_word ? IDLE : LOAD;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state != w_state_next) r_timer <= '0;
      else                         r_timer <= r_timer + 32'd1;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_words     <= '0;
      r_nwords    <= '0;
      r_word_idx  <= '0;
      r_grant_src <= '0;
      r_rr_ptr    <= SRC_SPI;
      r_uart_data <= '0;
    end else begin
      if (w_grant) begin
        r_words     <= w_frame_words;
        r_nwords    <= w_frame_nwords;
        r_word_idx  <= '0;
        r_grant_src <= w_pick;
        r_rr_ptr    <= rr_next(w_pick);
      end else if ((r_state == GAP) && (w_state_next == LOAD)) begin
        r_word_idx  <= r_word_idx + 2'd1;
      end
      if (r_state == LOAD) r_uart_data <= r_words[r_word_idx];
    end
  end

  assign bus.uart_data   = r_uart_data;
  assign bus.uart_start  = (r_state == HOLD);
  assign bus.busy        = (r_state != IDLE);
  assign bus.grant_src   = r_grant_src;
  assign bus.spi_overrun = r_overrun;

endmodule
`default_nettype wire
